// File: rtl/draw_projectile_if.sv
// vga_if: one hop of the VGA overlay chain.
//   hcount, vcount : pixel counters (11 bits)
//   hsync, vsync   : sync strobes
//   hblnk, vblnk   : blanking flags (pixel inactive while either is set)
//   rgb            : 12-bit colour {r[3:0], g[3:0], b[3:0]}
// Modport "in" is used by a stage consuming the stream, "out" by the stage producing it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_projectile.sv
// draw_projectile: overlays a 32x32 thrown projectile onto the VGA stream and
// runs its flight physics once per frame (rising edge of vblnk).
// Ports:
//   clk60MHz   : pixel clock, everything on its rising edge
//   rst        : synchronous active-high reset
//   throw      : single-cycle launch request, honoured only while idle
//   power[3:0] : launch strength, sampled with throw
//   rgb_pixel  : sprite ROM data, one cycle after pixel_addr
//   pixel_addr : sprite ROM address {row[4:0], col[4:0]}
//   busy       : a throw is in progress
//   hit, land  : one-cycle outcome pulses, cycle after the deciding frame tick
//   in / out   : video stream; out is in delayed by 2 cycles with the sprite overlaid
module draw_projectile #(
    parameter int          START_X     = 100,
    parameter int          START_Y     = 500,
    parameter int          GROUND_Y    = 500,
    parameter int          V0_OFFSET   = 8,
    parameter int          GRAVITY     = 1,
    parameter int          CRATE_X     = 600,
    parameter int          CRATE_Y     = 436,
    parameter int          CRATE_SIZE  = 64,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic        throw,
    input  logic [3:0]  power,
    input  logic [11:0] rgb_pixel,
    output logic [9:0]  pixel_addr,
    output logic        busy,
    output logic        hit,
    output logic        land,
    vga_if.in           in,
    vga_if.out          out
);
    localparam logic signed [11:0] START_X_S  = 12'(START_X);
    localparam logic signed [11:0] START_Y_S  = 12'(START_Y);
    localparam logic signed [11:0] GROUND_Y_S = 12'(GROUND_Y);
    localparam logic signed [11:0] CRATE_X_S  = 12'(CRATE_X);
    localparam logic signed [11:0] CRATE_R_S  = 12'(CRATE_X + CRATE_SIZE);
    localparam logic signed [11:0] CRATE_Y_S  = 12'(CRATE_Y);
    localparam logic signed [11:0] SPRITE_S   = 12'sd32;
    localparam logic signed [7:0]  GRAVITY_S  = 8'(GRAVITY);
    localparam logic [7:0]         V0_U       = 8'(V0_OFFSET);

    typedef enum logic [1:0] {IDLE, ARMED, FLIGHT, DONE} state_t;

    state_t             state, state_next;
    logic signed [11:0] pos_x, pos_x_next;
    logic signed [11:0] pos_y, pos_y_next;
    logic [4:0]         vx, vx_next;
    logic signed [7:0]  vy, vy_next;
    logic               hit_next, land_next;
    logic               vblnk_prev;
    logic               tick;
    logic signed [11:0] fx, fy;
    logic signed [7:0]  fvy;
    logic               visible;

    // Box [x, x+32) overlaps the crate horizontally and its bottom edge is below the crate top.
    function automatic logic hits_crate(input logic signed [11:0] x, input logic signed [11:0] y);
        return (x < CRATE_R_S) && ((x + SPRITE_S) > CRATE_X_S) && ((y + SPRITE_S) > CRATE_Y_S);
    endfunction

    // Counter c lies in [p, p+32); done in 13 bits so a negative p cannot wrap.
    function automatic logic in_span(input logic [10:0] c, input logic signed [11:0] p);
        logic signed [12:0] d;
        d = $signed({2'b00, c}) - $signed({p[11], p});
        return (d >= 13'sd0) && (d < 13'sd32);
    endfunction

    assign tick    = in.vblnk & ~vblnk_prev;
    assign busy    = (state != IDLE);
    assign visible = (state != IDLE);

    // Only the low 5 bits of the offsets matter, so 5-bit subtraction is exact.
    assign pixel_addr = {in.vcount[4:0] - pos_y[4:0], in.hcount[4:0] - pos_x[4:0]};

    // Candidate physics step for a FLIGHT tick.
    assign fx  = pos_x + $signed({7'b0, vx});
    assign fy  = pos_y + $signed({{4{vy[7]}}, vy});
    assign fvy = vy + GRAVITY_S;

    always_comb begin
        state_next = state;
        pos_x_next = pos_x;
        pos_y_next = pos_y;
        vx_next    = vx;
        vy_next    = vy;
        hit_next   = 1'b0;
        land_next  = 1'b0;
        case (state)
            IDLE: begin
                pos_x_next = START_X_S;
                pos_y_next = START_Y_S;
                if (throw) begin
                    vx_next    = {1'b0, power};
                    vy_next    = $signed(8'd0 - ({4'b0, power} + V0_U));
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (tick) state_next = FLIGHT;
            end
            FLIGHT: begin
                if (tick) begin
                    pos_x_next = fx;
                    pos_y_next = fy;
                    vy_next    = fvy;
                    // Hit is tested first so it wins over a simultaneous landing.
                    if (hits_crate(fx, fy)) begin
                        hit_next   = 1'b1;
                        state_next = DONE;
                    end else if ((vy > 8'sd0) && (fy >= GROUND_Y_S)) begin
                        pos_y_next = GROUND_Y_S;
                        land_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (tick) begin
                    pos_x_next = START_X_S;
                    pos_y_next = START_Y_S;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state      <= IDLE;
            pos_x      <= START_X_S;
            pos_y      <= START_Y_S;
            vx         <= 5'd0;
            vy         <= 8'sd0;
            hit        <= 1'b0;
            land       <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            state      <= state_next;
            pos_x      <= pos_x_next;
            pos_y      <= pos_y_next;
            vx         <= vx_next;
            vy         <= vy_next;
            hit        <= hit_next;
            land       <= land_next;
            vblnk_prev <= in.vblnk;
        end
    end

    // ---- stage 1: register the upstream stream, aligned with rgb_pixel ----
    logic [10:0] hcount_p1, vcount_p1;
    logic        hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;
    logic [11:0] rgb_p1;
    logic        sprite_on_p1;

    always_ff @(posedge clk60MHz) begin
        hcount_p1 <= in.hcount;
        vcount_p1 <= in.vcount;
        hsync_p1  <= in.hsync;
        vsync_p1  <= in.vsync;
        hblnk_p1  <= in.hblnk;
        vblnk_p1  <= in.vblnk;
        rgb_p1    <= in.rgb;
    end

    assign sprite_on_p1 = visible && !hblnk_p1 && !vblnk_p1
                       && in_span(hcount_p1, pos_x) && in_span(vcount_p1, pos_y)
                       && (rgb_pixel != TRANSPARENT);

    // ---- stage 2: overlay and drive the downstream stream ----
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            out.hcount <= 11'd0;
            out.vcount <= 11'd0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= 12'd0;
        end else begin
            out.hcount <= hcount_p1;
            out.vcount <= vcount_p1;
            out.hsync  <= hsync_p1;
            out.vsync  <= vsync_p1;
            out.hblnk  <= hblnk_p1;
            out.vblnk  <= vblnk_p1;
            out.rgb    <= sprite_on_p1 ? rgb_pixel : rgb_p1;
        end
    end
endmodule

// File: doc/draw_projectile.md
# draw_projectile

Pipelined VGA overlay stage that draws a 32x32 thrown projectile and runs its per-frame flight physics. It sits directly downstream of the crate drawing stage in the `vga_if` chain. It consumes that stage's timing and RGB stream, and overlays the projectile sprite fetched from an external sprite ROM. It also reports whether the throw hit the crate or landed on the ground.

## Interface
Parameters:
- START_X, 100, launch x position (pixels, top-left of sprite)
- START_Y, 500, launch y position; also the idle/parked position
- GROUND_Y, 500, flight ends with "land" when y >= GROUND_Y while falling
- V0_OFFSET, 8, added to power to form initial upward speed
- GRAVITY, 1, added to vertical velocity every frame
- CRATE_X, 600; CRATE_Y, 436; CRATE_SIZE, 64: crate hit box
- TRANSPARENT, 12'hF0F, sprite colour treated as see-through

Ports:
- clk60MHz  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- throw  in  1  single-cycle launch request
- power  in  4  launch strength, sampled with throw
- rgb_pixel  in  12  sprite ROM data, valid 1 cycle after pixel_addr
- pixel_addr  out  10  sprite ROM address {row[4:0], col[4:0]}
- busy  out  1  high from accepted throw until DONE exits
- hit  out  1  one-cycle pulse, projectile touched crate
- land  out  1  one-cycle pulse, projectile reached ground
- in  vga_if.in  —  upstream hcount/vcount (11b), hsync/vsync/hblnk/vblnk, rgb (12b)
- out  vga_if.out  —  same signals, delayed 2 cycles, rgb overlaid

## Operation
- Frame tick: a one-cycle internal strobe on the rising edge of in.vblnk, detected with a registered previous value. Physics updates only on a tick.
- State: pos_x, pos_y (signed 12b), vx (unsigned 5b), vy (signed 8b).
- FSM:
  - IDLE: pos = (START_X, START_Y), sprite hidden. throw=1 latches vx=power, vy=-(power+V0_OFFSET), and moves to ARMED. busy=1 from the next cycle.
  - ARMED: on the next tick go to FLIGHT. No position change in this state.
  - FLIGHT: on each tick, in order: pos_x += vx; pos_y += vy; vy += GRAVITY. Then evaluate against the new position:
    - Hit: box [pos_x, pos_x+32) overlaps [CRATE_X, CRATE_X+CRATE_SIZE) and pos_y+32 > CRATE_Y. Pulse hit and go to DONE.
    - Otherwise land: vy_old > 0 and pos_y >= GROUND_Y. Clamp pos_y to GROUND_Y, pulse land, and go to DONE.
    - Hit has priority if both conditions are true on the same tick.
  - DONE: the sprite stays visible at its final position. On the next tick go to IDLE; busy drops in the same cycle.
- throw is ignored in every state except IDLE.
- Sprite is visible in ARMED, FLIGHT and DONE.
- pixel_addr = {(in.vcount - pos_y)[4:0], (in.hcount - pos_x)[4:0]}, computed combinationally from the upstream counters.
- Overlay at pipeline stage 2: if the delayed pixel is active (neither blank asserted), inside [pos_x, pos_x+32) x [pos_y, pos_y+32), sprite visible, and rgb_pixel != TRANSPARENT, then out.rgb = rgb_pixel. Otherwise out.rgb = delayed in.rgb.
- Hit tests use signed compares, so a negative pos_y (above the screen) is legal.

## Timing
- Video latency is exactly 2 cycles for all vga_if fields: stage-1 register, then stage-2 register.
- Position changes take effect on the tick cycle, inside vblank, so no frame ever shows a partially updated position.
- hit and land are registered and assert in the cycle after the tick. They are never high together.
- Reset values: all out.* = 0, pixel_addr reflects in.* at (START_X, START_Y), busy=0, hit=0, land=0, FSM=IDLE, pos=(START_X, START_Y), vx=vy=0.
- Reset mid-flight aborts the throw: no hit or land pulse, and the FSM returns to IDLE with the launch position.

## Test plan
- Reset, then stream 1 frame with no throw: out = in delayed by 2 cycles, busy=0, sprite visible only when rgb_pixel ≠ TRANSPARENT inside the launch box? No: the sprite is hidden in IDLE, so out.rgb must equal in.rgb everywhere.
- power=4, defaults: after 1 FLIGHT tick pos=(104,488) and vy=-11. After 25 ticks pos=(200,500); land pulses once, no hit. Next tick returns to IDLE and busy=0.
- CRATE_X=200, power=4: first hit on FLIGHT tick 18 with pos=(172,437). One hit pulse, no land pulse.
- throw asserted during FLIGHT with power=15: ignored, and the trajectory is unchanged from the power=4 run.
- Sprite pixel at (pos_x+3, pos_y+5) returns TRANSPARENT: out.rgb = upstream rgb. Returns 12'h0A0: out.rgb = 12'h0A0, and pixel_addr at that upstream pixel is {5'd5, 5'd3}.
- Assert rst at FLIGHT tick 10: next cycle busy=0, no hit or land pulse, and pos=(100,500).
